inst_decoder: RTL and testbench

Front end of the multi-phase CPU. Fetches one 32-bit instruction word per instruction over a request/acknowledge port and sequences the five one-hot execution phases. Splits the instruction register into the operand fields the ALU consumes (`ikind`, `ia`, `sim8`, `im16`, register addresses). Owns the PC and updates it from the ALU's `z` / `ct_taken` results at writeback.

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/inst_class.sv | 31 +++
 rtl/inst_decoder.sv | 140 ++++++++++++++
 tb/tb_inst_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: phase encoding, instruction
// field positions, and the ikind class patterns used by the decoder and ALU.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One-hot phase bit indices.
    localparam int unsigned PH_FETCH_BIT  = 0;
    localparam int unsigned PH_DECODE_BIT = 1;
    localparam int unsigned PH_EXEC_BIT   = 2;
    localparam int unsigned PH_MEM_BIT    = 3;
    localparam int unsigned PH_WB_BIT     = 4;

    typedef enum logic [4:0] {
        PH_FETCH  = 5'b1 << PH_FETCH_BIT,
        PH_DECODE = 5'b1 << PH_DECODE_BIT,
        PH_EXEC   = 5'b1 << PH_EXEC_BIT,
        PH_MEM    = 5'b1 << PH_MEM_BIT,
        PH_WB     = 5'b1 << PH_WB_BIT
    } phase_t;

    // Instruction register field positions.
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned MOD_MSB  = 23;
    localparam int unsigned MOD_LSB  = 22;
    localparam int unsigned REG_MSB  = 21;
    localparam int unsigned REG_LSB  = 19;
    localparam int unsigned RM_MSB   = 18;
    localparam int unsigned RM_LSB   = 16;
    localparam int unsigned SIM8_MSB = 15;
    localparam int unsigned SIM8_LSB = 8;
    localparam int unsigned IM16_MSB = 15;
    localparam int unsigned IM16_LSB = 0;

    // An ikind pattern: bits where care=1 must equal value.
    typedef struct packed {
        logic [9:0] value;
        logic [9:0] care;
    } kind_pat_t;

    localparam kind_pat_t PAT_LD  = '{value: 10'b1000_1010_01, care: 10'b1111_1110_11};
    localparam kind_pat_t PAT_ST  = '{value: 10'b1000_1000_01, care: 10'b1111_1110_11};
    localparam kind_pat_t PAT_LIL = '{value: 10'b0110_0110_10, care: 10'b1111_1111_11};
    localparam kind_pat_t PAT_JR  = '{value: 10'b1111_1111_11, care: 10'b1111_1111_11};
    localparam kind_pat_t PAT_B   = '{value: 10'b1001_0000_11, care: 10'b1111_1111_11};

    // Register-register ALU ops: mod 11 with one of these opcode groups.
    localparam int unsigned RR_PAT_COUNT = 7;
    localparam kind_pat_t PAT_RR [RR_PAT_COUNT] = '{
        '{value: 10'b0000_0000_11, care: 10'b1111_1110_11},
        '{value: 10'b0010_1000_11, care: 10'b1111_1110_11},
        '{value: 10'b0010_0000_11, care: 10'b1111_1110_11},
        '{value: 10'b0000_1000_11, care: 10'b1111_1110_11},
        '{value: 10'b1111_0110_11, care: 10'b1111_1110_11},
        '{value: 10'b1000_1000_11, care: 10'b1111_1110_11},
        '{value: 10'b1000_0000_11, care: 10'b1111_1100_11}
    };

    function automatic logic kind_match(input logic [9:0] kind, input kind_pat_t pat);
        return ((kind ^ pat.value) & pat.care) == '0;
    endfunction

endpackage

// File: rtl/inst_class.sv
// Combinational instruction classifier: maps ikind onto the decoder's
// instruction classes using the shared cpu_pkg patterns.
module inst_class
    import cpu_pkg::*;
(
    input  logic [9:0] ikind,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_lil,
    output logic       is_jr,
    output logic       is_b,
    output logic       is_rr
);

    assign is_ld  = kind_match(ikind, PAT_LD);
    assign is_st  = kind_match(ikind, PAT_ST);
    assign is_lil = kind_match(ikind, PAT_LIL);
    assign is_jr  = kind_match(ikind, PAT_JR);
    assign is_b   = kind_match(ikind, PAT_B);

    // Register-register class: any of the RR opcode groups with mod 11.
    always_comb begin
        is_rr = 1'b0;
        for (int unsigned i = 0; i < RR_PAT_COUNT; i++) begin
            if (kind_match(ikind, PAT_RR[i])) begin
                is_rr = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_decoder.sv
// CPU front end: fetches instructions, sequences the five one-hot phases,
// exposes the instruction fields and owns the PC.
module inst_decoder
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] alu_z,
    input  logic        ct_taken,
    output logic [4:0]  phase,
    output logic [9:0]  ikind,
    output logic [2:0]  ia,
    output logic [7:0]  sim8,
    output logic [15:0] im16,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [31:0] pc
);

    phase_t      state;
    phase_t      state_next;
    logic [31:0] ir;
    logic [31:0] pc_next;
    logic [31:0] pc_seq;
    logic [31:0] br_off;

    logic is_ld;
    logic is_st;
    logic is_lil;
    logic is_jr;
    logic is_b;
    logic is_rr;
    logic mem_op;
    logic rf_write;
    logic known_op;

    // Instruction fields, combinational from ir.
    assign ikind      = {ir[OPC_MSB:OPC_LSB], ir[MOD_MSB:MOD_LSB]};
    assign ia         = ir[REG_MSB:REG_LSB];
    assign sim8       = ir[SIM8_MSB:SIM8_LSB];
    assign im16       = ir[IM16_MSB:IM16_LSB];
    assign rf_raddr_a = ir[REG_MSB:REG_LSB];
    assign rf_raddr_b = ir[RM_MSB:RM_LSB];

    inst_class u_inst_class (
        .ikind  (ikind),
        .is_ld  (is_ld),
        .is_st  (is_st),
        .is_lil (is_lil),
        .is_jr  (is_jr),
        .is_b   (is_b),
        .is_rr  (is_rr)
    );

    assign mem_op   = is_ld | is_st;
    assign rf_write = is_ld | is_lil | is_rr;
    // Unknown opcodes must never redirect the PC, whatever the ALU reports.
    assign known_op = is_ld | is_st | is_lil | is_jr | is_b | is_rr;
    assign rf_waddr = (is_ld | is_lil) ? ir[REG_MSB:REG_LSB] : ir[RM_MSB:RM_LSB];

    assign phase     = state;
    assign imem_addr = pc;

    // Phase state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= PH_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-phase selection; any illegal encoding falls back to FETCH.
    always_comb begin
        state_next = PH_FETCH;
        case (state)
            PH_FETCH:  state_next = imem_ack ? PH_DECODE : PH_FETCH;
            PH_DECODE: state_next = PH_EXEC;
            PH_EXEC:   state_next = PH_MEM;
            PH_MEM:    state_next = (mem_op && !dmem_ack) ? PH_MEM : PH_WB;
            PH_WB:     state_next = PH_FETCH;
            default:   state_next = PH_FETCH;
        endcase
    end

    // Phase-decoded request and write strobes.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        case (state)
            PH_FETCH: imem_req = 1'b1;
            PH_MEM: begin
                dmem_req = mem_op;
                dmem_we  = is_st;
            end
            PH_WB:    rf_we = rf_write;
            default: ;
        endcase
    end

    // Next PC: indirect jump, PC-relative branch, or sequential.
    always_comb begin
        pc_seq = pc + 32'd4;
        br_off = {{22{sim8[7]}}, sim8, 2'b00};
        if (ct_taken && known_op) begin
            pc_next = is_jr ? alu_z : pc_seq + br_off;
        end else begin
            pc_next = pc_seq;
        end
    end

    // Instruction register loads on fetch ack; PC advances at writeback.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir <= '0;
            pc <= RESET_PC;
        end else begin
            if (state == PH_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            if (state == PH_WB) begin
                pc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_inst_decoder.sv
// Directed self-checking bench for inst_decoder.
module tb_inst_decoder;

    logic        CLK;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] alu_z;
    logic        ct_taken;
    logic [4:0]  phase;
    logic [9:0]  ikind;
    logic [2:0]  ia;
    logic [7:0]  sim8;
    logic [15:0] im16;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] pc;

    inst_decoder #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_z      (alu_z),
        .ct_taken   (ct_taken),
        .phase      (phase),
        .ikind      (ikind),
        .ia         (ia),
        .sim8       (sim8),
        .im16       (im16),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .pc         (pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          obs_cycles;
    int          obs_we;
    int          obs_req;
    logic        obs_dwe;
    logic [2:0]  obs_waddr;
    logic [31:0] last_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fields(input logic [31:0] w);
        return {w[31:22], w[21:19], w[18:16], w[15:0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        obs_cycles++;
        if (rf_we) obs_we++;
    endtask

    // Runs one instruction from a FETCH cycle through to the next FETCH.
    task automatic exec_instr(input logic [31:0] word, input int fetch_wait, input int mem_wait,
                              input bit mem_op, input bit stray, input logic ct, input logic [31:0] z);
        obs_cycles = 0;
        obs_we     = 0;
        obs_req    = 0;
        obs_dwe    = 1'b0;
        check("start_fetch", {27'd0, phase}, 32'h01);
        for (int i = 0; i < fetch_wait; i++) begin
            dmem_ack = stray && (i % 3 == 0);
            tick();
            dmem_ack = 1'b0;
            check("fetch_hold", {27'd0, phase}, 32'h01);
            check("ir_hold", {ikind, ia, rf_raddr_b, im16}, fields(last_word));
            check("fetch_req", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        last_word  = word;
        check("decode", {27'd0, phase}, 32'h02);
        check("fields", {ikind, ia, rf_raddr_b, im16}, fields(word));
        check("sim8", {24'd0, sim8}, {24'd0, word[15:8]});
        check("raddr_a", {29'd0, rf_raddr_a}, {29'd0, word[21:19]});
        ct_taken = ~ct;
        alu_z    = ~z;
        tick();
        check("exec", {27'd0, phase}, 32'h04);
        tick();
        check("mem", {27'd0, phase}, 32'h08);
        if (mem_op) begin
            for (int k = 0; k < mem_wait; k++) begin
                obs_req += int'(dmem_req);
                obs_dwe |= dmem_we;
                tick();
                check("mem_hold", {27'd0, phase}, 32'h08);
            end
            dmem_ack = 1'b1;
        end
        obs_req += int'(dmem_req);
        obs_dwe |= dmem_we;
        tick();
        dmem_ack = 1'b0;
        check("wb", {27'd0, phase}, 32'h10);
        obs_waddr = rf_waddr;
        ct_taken  = ct;
        alu_z     = z;
        tick();
        ct_taken  = 1'b0;
        alu_z     = 32'd0;
        check("next_fetch", {27'd0, phase}, 32'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        dmem_ack   = 1'b0;
        alu_z      = 32'd0;
        ct_taken   = 1'b0;
        last_word  = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_phase", {27'd0, phase}, 32'h01);
        check("rst_pc", pc, 32'h0);
        check("rst_ikind", {22'd0, ikind}, 32'h0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd1);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        RST = 1'b0;

        // ADD reg0, rm1
        exec_instr(32'h01C1_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("add_cycles", obs_cycles, 5);
        check("add_we", obs_we, 1);
        check("add_waddr", {29'd0, obs_waddr}, 32'd1);
        check("add_pc", pc, 32'h4);

        // LD reg1, [rm2+8], data ack delayed 3 cycles
        exec_instr(32'h8B4A_0800, 0, 3, 1'b1, 1'b0, 1'b0, 32'h0);
        check("ld_cycles", obs_cycles, 8);
        check("ld_req_cycles", obs_req, 4);
        check("ld_we_store", {31'd0, obs_dwe}, 32'd0);
        check("ld_we", obs_we, 1);
        check("ld_waddr", {29'd0, obs_waddr}, 32'd1);
        check("ld_pc", pc, 32'h8);

        // JR taken to 0x100
        exec_instr(32'hFFC0_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        check("jr_imem_addr", imem_addr, 32'h100);
        check("jr_we", obs_we, 0);

        // JR to 0x20, then B -2 taken -> 0x1C
        exec_instr(32'hFFC0_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        check("jr2_pc", pc, 32'h20);
        exec_instr(32'h90C0_FE00, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("b_taken_pc", pc, 32'h1C);
        check("b_we", obs_we, 0);

        // B not taken -> sequential
        exec_instr(32'h90C0_FE00, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("b_nt_pc", pc, 32'h20);

        // LIL reg3: writes ir[21:19]
        exec_instr(32'h669D_1234, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("lil_we", obs_we, 1);
        check("lil_waddr", {29'd0, obs_waddr}, 32'd3);
        check("lil_pc", pc, 32'h24);

        // Unknown opcode with ct_taken: no write, no access, pc += 4
        exec_instr(32'h0F00_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0500);
        check("unk_we", obs_we, 0);
        check("unk_req", obs_req, 0);
        check("unk_pc", pc, 32'h28);

        // Fetch ack withheld 10 cycles with stray dmem_ack pulses
        exec_instr(32'h29D8_0000, 10, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("hold_cycles", obs_cycles, 15);
        check("hold_we", obs_we, 1);
        check("hold_waddr", {29'd0, obs_waddr}, 32'd0);
        check("hold_pc", pc, 32'h2C);

        // PC wrap past 0xFFFF_FFFC
        exec_instr(32'hFFC0_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_jr_pc", pc, 32'hFFFF_FFFC);
        exec_instr(32'h01C1_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        exec_instr(32'h01C1_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_st_pc", pc, 32'h4);

        // ST, reset asserted during the memory wait
        imem_ack   = 1'b1;
        imem_rdata = 32'h8942_0000;
        tick();
        imem_ack   = 1'b0;
        tick();
        tick();
        check("st_mem", {27'd0, phase}, 32'h08);
        check("st_req", {31'd0, dmem_req}, 32'd1);
        check("st_we", {31'd0, dmem_we}, 32'd1);
        tick();
        tick();
        check("st_wait_req", {31'd0, dmem_req}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        check("rst_mid_phase", {27'd0, phase}, 32'h01);
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_ikind", {22'd0, ikind}, 32'h0);
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_phase", {27'd0, phase}, 32'h01);
        check("late_ack_pc", pc, 32'h0);
        last_word = 32'd0;
        exec_instr(32'h01C1_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("post_rst_pc", pc, 32'h4);
        check("post_rst_cycles", obs_cycles, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
